cl_axi_bram_slave: RTL

- AXI-4 slave holding a 64-bit-wide on-chip RAM.
- Sits directly downstream of the BAR1 AXI-Lite-to-AXI-4 converter and consumes its s_axi_* channels.
- Drives the rsta_busy/rstb_busy status the converter gates on.
- Independent write and read engines; FIXED and INCR bursts; per-byte strobes.

---
 rtl/cl_axi_bram_pkg.sv | 35 +++
 rtl/cl_axi_bram_slave_if.sv | 67 ++++++
 rtl/cl_bram_sdp.sv | 35 +++
 rtl/cl_axi_bram_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_axi_bram_pkg.sv
// Shared types and constants for the AXI-4 BRAM slave: burst encodings,
// response codes, engine state enums and the fixed bus widths.
package cl_axi_bram_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  localparam int ID_W   = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_e;

  // WRAP and the reserved encoding are not served; neither is any beat wider than the bus.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd3);
  endfunction

endpackage

// File: rtl/cl_axi_bram_slave_if.sv
// AXI-4 channel bundle between the BAR1 converter (master) and the BRAM slave.
interface cl_axi_bram_slave_if #(
  parameter int ADDR_W = 32
);
  import cl_axi_bram_pkg::*;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/cl_bram_sdp.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module cl_bram_sdp #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write; only lanes with their strobe set are touched.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; a same-cycle write to the word is not visible (read-first).
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cl_axi_bram_slave.sv
// AXI-4 slave in front of a 64-bit on-chip RAM, fed by the BAR1 converter.
// Independent write and read engines, FIXED/INCR bursts, byte strobes.
// Build option: define CL_BRAM_INIT_CLEAR_EN to zero the whole RAM after
// reset release (busy held for DEPTH+1 cycles); otherwise busy lasts BUSY_CYC.
module cl_axi_bram_slave
  import cl_axi_bram_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int BUSY_CYC = 2
) (
  input  logic               clk_main_a0,
  input  logic               rst_main_n,
  output logic               rsta_busy,
  output logic               rstb_busy,
  cl_axi_bram_slave_if.slave s_axi
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef CL_BRAM_INIT_CLEAR_EN
  localparam int BUSY_LAST = DEPTH;
`else
  localparam int BUSY_LAST = (BUSY_CYC > 1) ? BUSY_CYC - 1 : 0;
`endif
  localparam int CNT_W = $clog2(BUSY_LAST + 1) + 1;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_W+2:3];
  endfunction

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:IDX_W+3];
  endfunction

  // Busy / init-clear sequencer
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  // Count cycles since reset release; busy falls once the last count is reached.
  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (busy_q) begin
      if (busy_cnt_q == CNT_W'(BUSY_LAST)) busy_d = 1'b0;
      else                                 busy_cnt_d = busy_cnt_q + 1'b1;
    end
  end

`ifdef CL_BRAM_INIT_CLEAR_EN
  assign clr_we  = busy_q && (busy_cnt_q != CNT_W'(DEPTH));
  assign clr_idx = busy_cnt_q[IDX_W-1:0];
`else
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Write engine
  wstate_e           w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [8:0]        w_cnt_q, w_cnt_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic              w_aerr_q, w_aerr_d;
  logic              w_lerr_q, w_lerr_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              w_we;
  logic              w_last_beat;

  assign w_last_beat = (w_cnt_q == 9'd1);

  // Write FSM next-state: AW capture, counted W beats, then hold B until accepted.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_aerr_d  = w_aerr_q;
    w_lerr_d  = w_lerr_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          w_id_d    = s_axi.awid;
          w_idx_d   = addr_idx(s_axi.awaddr);
          w_cnt_d   = {1'b0, s_axi.awlen} + 9'd1;
          w_burst_d = s_axi.awburst;
          w_aerr_d  = burst_bad(s_axi.awburst, s_axi.awsize) || addr_oor(s_axi.awaddr);
          w_lerr_d  = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          w_we    = !w_aerr_q;
          w_cnt_d = w_cnt_q - 9'd1;
          if (s_axi.wlast != w_last_beat) w_lerr_d = 1'b1;
          if (w_burst_q == BURST_INCR) w_idx_d = w_idx_q + 1'b1;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = (w_aerr_q || w_lerr_q || !s_axi.wlast) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !busy_d;
    wready_d  = (w_state_d == W_DATA);
  end

  // Read engine
  rstate_e           r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [IDX_W-1:0]  r_nidx;
  logic [8:0]        r_cnt_q, r_cnt_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_err_q, r_err_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign r_nidx = (r_burst_q == BURST_INCR) ? r_idx_q + 1'b1 : r_idx_q;

  // Read FSM next-state: issue RAM read, wait one cycle, present beat until accepted.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ram_re    = 1'b0;
    ram_raddr = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_id_d    = s_axi.arid;
          r_idx_d   = addr_idx(s_axi.araddr);
          r_cnt_d   = {1'b0, s_axi.arlen} + 9'd1;
          r_burst_d = s_axi.arburst;
          r_err_d   = burst_bad(s_axi.arburst, s_axi.arsize) || addr_oor(s_axi.araddr);
          ram_re    = 1'b1;
          ram_raddr = addr_idx(s_axi.araddr);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rvalid_d  = 1'b1;
        rdata_d   = r_err_q ? '0 : ram_rdata;
        rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (r_cnt_q == 9'd1);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi.rready && rvalid_q) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (r_cnt_q == 9'd1) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d   = r_nidx;
            r_cnt_d   = r_cnt_q - 9'd1;
            ram_re    = 1'b1;
            ram_raddr = r_nidx;
            r_state_d = R_WAIT;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE) && !busy_d;
  end

  // Control and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      busy_q     <= 1'b1;
      busy_cnt_q <= '0;
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // Burst bookkeeping; only meaningful while its engine is active, so no reset.
  always_ff @(posedge clk_main_a0) begin
    w_id_q    <= w_id_d;
    w_idx_q   <= w_idx_d;
    w_cnt_q   <= w_cnt_d;
    w_burst_q <= w_burst_d;
    w_aerr_q  <= w_aerr_d;
    w_lerr_q  <= w_lerr_d;
    r_id_q    <= r_id_d;
    r_idx_q   <= r_idx_d;
    r_cnt_q   <= r_cnt_d;
    r_burst_q <= r_burst_d;
    r_err_q   <= r_err_d;
  end

  cl_bram_sdp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk_main_a0),
    .we    (clr_we || w_we),
    .waddr (clr_we ? clr_idx : w_idx_q),
    .wdata (clr_we ? '0 : s_axi.wdata),
    .wstrb (clr_we ? '1 : s_axi.wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign rsta_busy     = busy_q;
  assign rstb_busy     = busy_q;
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rid     = r_id_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

endmodule
